// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: operand forwarding, load-use and long-op (RAW/WAW/structural) stalls,
// single-entry scoreboard for the unpipelined multi-cycle unit, saturating stall counter.
module hazard_scoreboard #(
    parameter int NSRC     = 3,
    parameter int REGW     = 4,
    parameter int LONG_LAT = 3,
    parameter int CNTW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*REGW-1:0] RA_D,
    input  logic [NSRC-1:0]      SrcValidD,
    input  logic [REGW-1:0]      WA_D,
    input  logic                 RegWriteD,
    input  logic                 LongOpD,
    input  logic [NSRC*REGW-1:0] RA_E,
    input  logic [REGW-1:0]      WA_E,
    input  logic [REGW-1:0]      WA_M,
    input  logic [REGW-1:0]      WA_W,
    input  logic                 RegWriteE,
    input  logic                 MemtoRegE,
    input  logic                 LongOpE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCWrPendingF,
    input  logic                 PCSrcW,
    input  logic                 BranchMissed,
    output logic [2*NSRC-1:0]    ForwardE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 LongBusy,
    output logic [CNTW-1:0]      StallCnt
);
    localparam int CW = $clog2(LONG_LAT + 1);

    logic [CW-1:0]   long_cnt_q, long_cnt_d;
    logic [REGW-1:0] long_dst_q, long_dst_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0] hit_e, hit_l;
    logic            issue, cnt_gt1, ldr_stall, long_raw, long_waw, long_struct, haz_stall;

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            assign ForwardE[2*i +: 2] = (RA_E[i*REGW +: REGW] == WA_M && RegWriteM) ? 2'b10 :
                                        (RA_E[i*REGW +: REGW] == WA_W && RegWriteW) ? 2'b01 : 2'b00;
            assign hit_e[i] = SrcValidD[i] && RA_D[i*REGW +: REGW] == WA_E;
            assign hit_l[i] = SrcValidD[i] && RA_D[i*REGW +: REGW] == long_dst_q;
        end
    endgenerate

    // At LongCnt == 1 the long unit writes in the first half-cycle, so readers need no stall.
    always_comb begin
        issue       = LongOpE && RegWriteE;
        cnt_gt1     = long_cnt_q > CW'(1);
        ldr_stall   = (|hit_e) && MemtoRegE && RegWriteE;
        long_raw    = ((|hit_e) && issue) || ((|hit_l) && cnt_gt1);
        long_waw    = RegWriteD && ((WA_D == long_dst_q && cnt_gt1) || (WA_D == WA_E && LongOpE));
        long_struct = LongOpD && (cnt_gt1 || LongOpE);
        haz_stall   = ldr_stall || long_raw || long_waw || long_struct;
        long_cnt_d  = issue ? CW'(LONG_LAT) : (long_cnt_q != '0) ? long_cnt_q - CW'(1) : long_cnt_q;
        long_dst_d  = issue ? WA_E : long_dst_q;
        stall_cnt_d = (haz_stall && stall_cnt_q != '1) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            long_cnt_q  <= '0;
            long_dst_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            long_cnt_q  <= long_cnt_d;
            long_dst_q  <= long_dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallD   = haz_stall;
    assign StallF   = haz_stall || PCWrPendingF;
    assign FlushE   = haz_stall;
    assign FlushD   = PCWrPendingF || PCSrcW || BranchMissed;
    assign LongBusy = long_cnt_q != '0;
    assign StallCnt = stall_cnt_q;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the five-stage pipeline, the successor to the fixed two-operand hazard unit. Takes raw register indices from D, E, M and W and computes the match signals internally. Forwarding select is generated for NSRC source operands. Adds a single-entry scoreboard for an unpipelined multi-cycle unit (multiply/divide) with RAW, WAW and structural stalls, plus a saturating stall-cycle counter for performance monitoring.

## Interface
- NSRC, 3, source operands per instruction
- REGW, 4, register index width
- LONG_LAT, 3, cycles from long-op issue in E to register-file write (≥2)
- CNTW, 16, stall counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- RA_D  in  NSRC*REGW  D-stage source indices, operand i at [i*REGW +: REGW]
- SrcValidD  in  NSRC  operand i of D instruction is read
- WA_D  in  REGW  D-stage destination
- RegWriteD, LongOpD  in  1  D instruction writes a register / is a long op
- RA_E  in  NSRC*REGW  E-stage source indices
- WA_E, WA_M, WA_W  in  REGW  destinations in E/M/W
- RegWriteE, MemtoRegE, LongOpE  in  1  E-stage controls
- RegWriteM, RegWriteW  in  1  M/W write enables; pipeline deasserts these for long ops
- PCWrPendingF, PCSrcW, BranchMissed  in  1  control-flow hazards, same meaning as today
- ForwardE  out  2*NSRC  operand i select at [2i+1:2i]: 10 = M, 01 = W, 00 = regfile
- StallF, StallD, FlushD, FlushE  out  1  pipeline control
- LongBusy  out  1  long unit occupied
- StallCnt  out  CNTW  cycles with StallD high, saturating

## Operation
- Forwarding (combinational, per operand i):
  - 10 if RA_E_i == WA_M and RegWriteM.
  - Otherwise 01 if RA_E_i == WA_W and RegWriteW.
  - Otherwise 00.
  - M has priority over W.
- srcHit_i(X) = SrcValidD[i] and RA_D_i == X.
- ldrStall: any srcHit_i(WA_E) with MemtoRegE and RegWriteE.
- Scoreboard registers:
  - LongCnt, width clog2(LONG_LAT+1).
  - LongDst, REGW.
  - LongBusy = (LongCnt != 0).
- Issue: LongOpE and RegWriteE loads LongCnt = LONG_LAT and LongDst = WA_E at the next edge. Otherwise, if LongCnt != 0, LongCnt decrements. The long unit writes the register file in the cycle LongCnt == 1.
- longRaw:
  - any srcHit_i(WA_E) with LongOpE and RegWriteE, or
  - any srcHit_i(LongDst) with LongCnt > 1.
  - At LongCnt == 1 there is no stall: write-first-half / read-second-half register file.
- longWaw: RegWriteD and WA_D == LongDst and LongCnt > 1; also WA_D == WA_E when LongOpE.
- longStruct: LongOpD while (LongCnt > 1 or LongOpE).
- hazStall = ldrStall | longRaw | longWaw | longStruct.
- Pipeline control:
  - StallD = hazStall.
  - StallF = hazStall | PCWrPendingF.
  - FlushE = hazStall.
  - FlushD = PCWrPendingF | PCSrcW | BranchMissed.
- StallCnt increments on every edge with StallD = 1 and holds at all-ones.
- An issued long op is never cancelled. A flush does not clear the scoreboard, because the op has already passed E.

## Timing
- Reset (asynchronous) clears LongCnt, LongDst and StallCnt. All outputs are 0 during and after reset, given inputs 0.
- Forward and stall outputs are combinational from current inputs and registers, with zero latency.
- Long op in E at cycle t:
  - LongBusy is 1 from t+1 to t+LONG_LAT.
  - A dependent reader in D is stalled in cycles t .. t+LONG_LAT−1 and released at t+LONG_LAT.
- LongOpE at the same edge as LongCnt == 1 reloads to LONG_LAT; the new op wins.
- LongDst equal to R0..R(2^REGW−1) is treated uniformly, with no special register.
- Reset asserted mid-countdown clears the scoreboard immediately. No stall occurs in the next cycle.

## Test plan
- Forwarding: RA_E = {3,5,7}, WA_M = 5, RegWriteM = 1, WA_W = 5, RegWriteW = 1 → ForwardE = {00,10,00} (op0 → 00, op1 → 10, op2 → 00). Drop RegWriteM → op1 = 01.
- Load-use: MemtoRegE = RegWriteE = 1, WA_E = 4, RA_D op1 = 4 valid → StallF = StallD = FlushE = 1 for one cycle. With SrcValidD[1] = 0 → no stall.
- Long RAW, LONG_LAT = 3: LongOpE, WA_E = 9 at t, D reads R9 → StallD high at t, t+1, t+2; low at t+3. LongBusy high t+1..t+3.
- WAW and structural: during countdown, D with WA_D = LongDst, or LongOpD = 1, stalls until LongCnt == 1. A D write to another register does not stall.
- Control flow: BranchMissed = 1 → FlushD = 1, StallD = 0. PCWrPendingF = 1 → StallF = FlushD = 1. Combined with ldrStall → all four asserted.
- Counter and reset: hold a stall 5 cycles → StallCnt = 5. Force near saturation → sticks at 2^CNTW−1. Assert reset mid-countdown → LongBusy = 0 and StallCnt = 0 asynchronously.
